// File: rtl/reg_bank_sequencer.sv
// Command-driven sequencer for a bank of NREG registers using the FunSel op set.
// Commands queue in a small FIFO and are issued one per cycle as registered one-hot enables.
module reg_bank_sequencer #(
  parameter int N     = 8,
  parameter int NREG  = 4,
  parameter int SELW  = 2,
  parameter int DEPTH = 4,
  parameter int CW    = 4
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            CmdValid,
  output logic            CmdReady,
  input  logic [1:0]      CmdOp,
  input  logic [SELW-1:0] CmdSel,
  input  logic [N-1:0]    CmdData,
  input  logic [CW-1:0]   CmdCount,
  output logic [NREG-1:0] RegE,
  output logic [1:0]      FunSel,
  output logic [N-1:0]    I,
  output logic            Busy,
  output logic            Done,
  output logic            Err
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = PW + 1;
  localparam int EW = 2 + SELW + N + CW;
  localparam logic [SELW:0] NREG_L = (SELW+1)'(NREG);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Command FIFO
  logic [EW-1:0]   fifo_mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic            push;
  logic            pop;

  logic [1:0]      head_op;
  logic [SELW-1:0] head_sel;
  logic [N-1:0]    head_data;
  logic [CW-1:0]   head_count;
  logic            head_bad;

  // Working registers for the command being executed
  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [N-1:0]    data_q, data_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic            err_q, err_d;

  // Registered bank-facing outputs
  logic [NREG-1:0] reg_e_q, reg_e_d;
  logic [1:0]      fun_sel_q, fun_sel_d;
  logic [N-1:0]    i_q, i_d;
  logic            done_q, done_d;
  logic            err_out_q, err_out_d;

  logic [NREG-1:0] sel_onehot;

  assign CmdReady = (fill_q < FW'(DEPTH));
  assign push     = CmdValid && CmdReady;

  assign {head_op, head_sel, head_data, head_count} = fifo_mem[rd_ptr_q];
  assign head_bad = ({1'b0, head_sel} >= NREG_L);

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_onehot
      assign sel_onehot[gi] = (sel_q == SELW'(gi));
    end
  endgenerate

  always_ff @(posedge Clock) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {CmdOp, CmdSel, CmdData, CmdCount};
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    fill_d   = fill_q + FW'(push) - FW'(pop);
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sel_d     = sel_q;
    data_d    = data_q;
    rem_d     = rem_q;
    err_d     = err_q;
    pop       = 1'b0;
    reg_e_d   = '0;
    fun_sel_d = 2'b00;
    i_d       = '0;
    done_d    = 1'b0;
    err_out_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fill_q != '0) begin
          pop    = 1'b1;
          op_d   = head_op;
          sel_d  = head_sel;
          data_d = head_data;
          // Only inc/dec repeat; clear and load always issue exactly once
          rem_d  = head_op[1] ? head_count : '0;
          err_d  = head_bad;
          state_d = head_bad ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        reg_e_d   = sel_onehot;
        fun_sel_d = op_q;
        i_d       = (op_q == 2'b01) ? data_q : '0;
        if (rem_q == '0) begin
          state_d = S_DONE;
        end else begin
          rem_d = rem_q - CW'(1);
        end
      end
      S_DONE: begin
        done_d    = 1'b1;
        err_out_d = err_q;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      state_q   <= S_IDLE;
      op_q      <= 2'b00;
      sel_q     <= '0;
      data_q    <= '0;
      rem_q     <= '0;
      err_q     <= 1'b0;
      reg_e_q   <= '0;
      fun_sel_q <= 2'b00;
      i_q       <= '0;
      done_q    <= 1'b0;
      err_out_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      state_q   <= state_d;
      op_q      <= op_d;
      sel_q     <= sel_d;
      data_q    <= data_d;
      rem_q     <= rem_d;
      err_q     <= err_d;
      reg_e_q   <= reg_e_d;
      fun_sel_q <= fun_sel_d;
      i_q       <= i_d;
      done_q    <= done_d;
      err_out_q <= err_out_d;
    end
  end

  assign RegE   = reg_e_q;
  assign FunSel = fun_sel_q;
  assign I      = i_q;
  assign Done   = done_q;
  assign Err    = err_out_q;
  assign Busy   = (state_q != S_IDLE) || (fill_q != '0);

endmodule
